// File: rtl/param_cache_pkg.sv
`default_nettype none
// ============================================================================
// Module  : param_cache_pkg
// Purpose : Shared types and constants for the direct-mapped cache controller.
// Rev     : 1.0  initial release
// ============================================================================
package param_cache_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COMPARE   = 2'd1,
        WRITEBACK = 2'd2,
        ALLOCATE  = 2'd3
    } cache_state_t;

    localparam int LINE_BITS     = 256;
    localparam int OFFSET_BITS   = 5;
    localparam int WORD_SEL_BITS = 3;

    function automatic logic [LINE_BITS-1:0] replicate_word(input logic [31:0] word);
        return {(LINE_BITS/32){word}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/param_tag_array.sv
`default_nettype none
// ============================================================================
// Module  : param_tag_array
// Purpose : Per-set tag, valid and dirty state; combinational read, sync write.
// Rev     : 1.0  initial release
// ============================================================================
module param_tag_array #(
    parameter int SETS  = 8,
    parameter int IDX_W = 3,
    parameter int TAG_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] index,
    output logic [TAG_W-1:0] rd_tag,
    output logic             rd_valid,
    output logic             rd_dirty,
    input  logic             fill_en,
    input  logic [TAG_W-1:0] fill_tag,
    input  logic             set_dirty,
    input  logic             clr_dirty
);

    logic [SETS-1:0][TAG_W-1:0] tag_q, tag_d;
    logic [SETS-1:0]            valid_q, valid_d;
    logic [SETS-1:0]            dirty_q, dirty_d;

    assign rd_tag   = tag_q[index];
    assign rd_valid = valid_q[index];
    assign rd_dirty = dirty_q[index];

    always_comb begin
        tag_d   = tag_q;
        valid_d = valid_q;
        dirty_d = dirty_q;
        if (fill_en) begin
            tag_d[index]   = fill_tag;
            valid_d[index] = 1'b1;
            dirty_d[index] = 1'b0;
        end
        if (set_dirty) dirty_d[index] = 1'b1;
        if (clr_dirty) dirty_d[index] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_q   <= '0;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            tag_q   <= tag_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/param_cache_control.sv
`default_nettype none
// ============================================================================
// Module  : param_cache_control
// Purpose : Direct-mapped write-back/write-allocate cache controller.
//           Optional CACHE_PERF_EN adds hit/miss/writeback counters.
// Rev     : 1.0  initial release
// ============================================================================
module param_cache_control
    import param_cache_pkg::*;
#(
    parameter  int Sets      = 8,
    localparam int Set_index = $clog2(Sets) - 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mem_read,
    input  logic                   mem_write,
    input  logic [31:0]            mem_address,
    input  logic [31:0]            mem_wdata,
    input  logic [3:0]             mem_byte_enable,
    output logic [31:0]            mem_rdata,
    output logic                   mem_resp,
    output logic [31:0]            arr_write_en,
    output logic [Set_index:0]     arr_rindex,
    output logic [Set_index:0]     arr_windex,
    output logic [LINE_BITS-1:0]   arr_datain,
    input  logic [LINE_BITS-1:0]   arr_dataout,
    output logic                   pmem_read,
    output logic                   pmem_write,
    output logic [31:0]            pmem_address,
    output logic [LINE_BITS-1:0]   pmem_wdata,
    input  logic [LINE_BITS-1:0]   pmem_rdata,
    input  logic                   pmem_resp
`ifdef CACHE_PERF_EN
    ,
    output logic [31:0]            perf_hits,
    output logic [31:0]            perf_misses,
    output logic [31:0]            perf_writebacks
`endif
);

    localparam int IDX_W = Set_index + 1;
    localparam int TAG_W = 32 - OFFSET_BITS - IDX_W;

    cache_state_t         state_q, state_d;
    logic [31:2]          addr_q, addr_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [3:0]           be_q, be_d;
    logic                 write_q, write_d;
    logic                 mem_resp_q, mem_resp_d;
    logic [31:0]          mem_rdata_q, mem_rdata_d;
    logic                 pmem_read_q, pmem_read_d;
    logic                 pmem_write_q, pmem_write_d;
    logic [31:0]          pmem_address_q, pmem_address_d;
    logic [LINE_BITS-1:0] pmem_wdata_q, pmem_wdata_d;
    logic [31:0]          arr_write_en_q, arr_write_en_d;
    logic [LINE_BITS-1:0] arr_datain_q, arr_datain_d;

    logic [IDX_W-1:0]         idx;
    logic [TAG_W-1:0]         tag_lat;
    logic [WORD_SEL_BITS-1:0] word;
    logic [TAG_W-1:0]         rd_tag;
    logic                     rd_valid, rd_dirty, hit;
    logic                     fill_en, set_dirty, clr_dirty;
    logic                     unused_addr_bits;

    assign idx              = addr_q[OFFSET_BITS+Set_index:OFFSET_BITS];
    assign tag_lat          = addr_q[31:OFFSET_BITS+IDX_W];
    assign word             = addr_q[4:2];
    assign hit              = rd_valid && (rd_tag == tag_lat);
    assign unused_addr_bits = ^mem_address[1:0];

    param_tag_array #(
        .SETS  (Sets),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_tags (
        .clk       (clk),
        .rst       (rst),
        .index     (idx),
        .rd_tag    (rd_tag),
        .rd_valid  (rd_valid),
        .rd_dirty  (rd_dirty),
        .fill_en   (fill_en),
        .fill_tag  (tag_lat),
        .set_dirty (set_dirty),
        .clr_dirty (clr_dirty)
    );

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        be_d           = be_q;
        write_d        = write_q;
        mem_resp_d     = 1'b0;
        mem_rdata_d    = mem_rdata_q;
        pmem_read_d    = 1'b0;
        pmem_write_d   = 1'b0;
        pmem_address_d = pmem_address_q;
        pmem_wdata_d   = pmem_wdata_q;
        arr_write_en_d = '0;
        arr_datain_d   = arr_datain_q;
        fill_en        = 1'b0;
        set_dirty      = 1'b0;
        clr_dirty      = 1'b0;

        case (state_q)
            IDLE: begin
                // The request is still held during the response cycle; skip it.
                if ((mem_read || mem_write) && !mem_resp_q) begin
                    addr_d  = mem_address[31:2];
                    wdata_d = mem_wdata;
                    be_d    = mem_byte_enable;
                    write_d = mem_write;
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                if (hit) begin
                    if (write_q) begin
                        arr_write_en_d = {28'd0, be_q} << {word, 2'b00};
                        arr_datain_d   = replicate_word(wdata_q);
                        set_dirty      = 1'b1;
                    end else begin
                        mem_rdata_d = arr_dataout[{word, 5'b00000} +: 32];
                    end
                    mem_resp_d = 1'b1;
                    state_d    = IDLE;
                end else if (rd_valid && rd_dirty) begin
                    pmem_write_d   = 1'b1;
                    pmem_address_d = {rd_tag, idx, 5'b00000};
                    pmem_wdata_d   = arr_dataout;
                    state_d        = WRITEBACK;
                end else begin
                    pmem_read_d    = 1'b1;
                    pmem_address_d = {tag_lat, idx, 5'b00000};
                    state_d        = ALLOCATE;
                end
            end
            WRITEBACK: begin
                if (pmem_resp) begin
                    clr_dirty      = 1'b1;
                    pmem_read_d    = 1'b1;
                    pmem_address_d = {tag_lat, idx, 5'b00000};
                    state_d        = ALLOCATE;
                end else begin
                    pmem_write_d = 1'b1;
                end
            end
            ALLOCATE: begin
                if (pmem_resp) begin
                    fill_en        = 1'b1;
                    arr_write_en_d = '1;
                    arr_datain_d   = pmem_rdata;
                    state_d        = COMPARE;
                end else begin
                    pmem_read_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            addr_q         <= '0;
            wdata_q        <= '0;
            be_q           <= '0;
            write_q        <= 1'b0;
            mem_resp_q     <= 1'b0;
            mem_rdata_q    <= '0;
            pmem_read_q    <= 1'b0;
            pmem_write_q   <= 1'b0;
            pmem_address_q <= '0;
            pmem_wdata_q   <= '0;
            arr_write_en_q <= '0;
            arr_datain_q   <= '0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            be_q           <= be_d;
            write_q        <= write_d;
            mem_resp_q     <= mem_resp_d;
            mem_rdata_q    <= mem_rdata_d;
            pmem_read_q    <= pmem_read_d;
            pmem_write_q   <= pmem_write_d;
            pmem_address_q <= pmem_address_d;
            pmem_wdata_q   <= pmem_wdata_d;
            arr_write_en_q <= arr_write_en_d;
            arr_datain_q   <= arr_datain_d;
        end
    end

    assign mem_resp     = mem_resp_q;
    assign mem_rdata    = mem_rdata_q;
    assign pmem_read    = pmem_read_q;
    assign pmem_write   = pmem_write_q;
    assign pmem_address = pmem_address_q;
    assign pmem_wdata   = pmem_wdata_q;
    assign arr_write_en = arr_write_en_q;
    assign arr_datain   = arr_datain_q;
    assign arr_rindex   = idx;
    assign arr_windex   = idx;

`ifdef CACHE_PERF_EN
    logic        refill_q, refill_d;
    logic [31:0] perf_hits_q, perf_hits_d;
    logic [31:0] perf_misses_q, perf_misses_d;
    logic [31:0] perf_writebacks_q, perf_writebacks_d;

    // refill marks the guaranteed-hit re-compare that follows a line fill.
    always_comb begin
        refill_d          = refill_q;
        perf_hits_d       = perf_hits_q;
        perf_misses_d     = perf_misses_q;
        perf_writebacks_d = perf_writebacks_q;
        case (state_q)
            COMPARE: begin
                if (hit) begin
                    refill_d = 1'b0;
                    if (!refill_q) perf_hits_d = perf_hits_q + 32'd1;
                end else begin
                    perf_misses_d = perf_misses_q + 32'd1;
                end
            end
            WRITEBACK: if (pmem_resp) perf_writebacks_d = perf_writebacks_q + 32'd1;
            ALLOCATE:  if (pmem_resp) refill_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            refill_q          <= 1'b0;
            perf_hits_q       <= '0;
            perf_misses_q     <= '0;
            perf_writebacks_q <= '0;
        end else begin
            refill_q          <= refill_d;
            perf_hits_q       <= perf_hits_d;
            perf_misses_q     <= perf_misses_d;
            perf_writebacks_q <= perf_writebacks_d;
        end
    end

    assign perf_hits       = perf_hits_q;
    assign perf_misses     = perf_misses_q;
    assign perf_writebacks = perf_writebacks_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_param_cache_control.sv
`default_nettype none
// ============================================================================
// Module  : tb_param_cache_control
// Purpose : Self-checking bench with data-array and line-memory models.
// Rev     : 1.0  initial release
// ============================================================================
module tb_param_cache_control;

    localparam int LAT = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         mem_read, mem_write;
    logic [31:0]  mem_address, mem_wdata;
    logic [3:0]   mem_byte_enable;
    logic [31:0]  mem_rdata;
    logic         mem_resp;
    logic [31:0]  arr_write_en;
    logic [2:0]   arr_rindex, arr_windex;
    logic [255:0] arr_datain, arr_dataout;
    logic         pmem_read, pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata, pmem_rdata;
    logic         pmem_resp;
`ifdef CACHE_PERF_EN
    logic [31:0]  perf_hits, perf_misses, perf_writebacks;
`endif

    param_cache_control #(.Sets(8)) dut (
        .clk             (clk),
        .rst             (rst),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_byte_enable (mem_byte_enable),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp),
        .arr_write_en    (arr_write_en),
        .arr_rindex      (arr_rindex),
        .arr_windex      (arr_windex),
        .arr_datain      (arr_datain),
        .arr_dataout     (arr_dataout),
        .pmem_read       (pmem_read),
        .pmem_write      (pmem_write),
        .pmem_address    (pmem_address),
        .pmem_wdata      (pmem_wdata),
        .pmem_rdata      (pmem_rdata),
        .pmem_resp       (pmem_resp)
`ifdef CACHE_PERF_EN
        ,
        .perf_hits       (perf_hits),
        .perf_misses     (perf_misses),
        .perf_writebacks (perf_writebacks)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Data array: byte-write at the clock edge, combinational read with bypass.
    logic [255:0] darr [8];
    logic [31:0]  last_we = '0;

    always @(posedge clk) begin
        for (int b = 0; b < 32; b++)
            if (arr_write_en[b]) darr[arr_windex][8*b +: 8] <= arr_datain[8*b +: 8];
        if (arr_write_en != 32'd0) last_we <= arr_write_en;
    end

    always_comb begin
        arr_dataout = darr[arr_rindex];
        if (arr_windex == arr_rindex)
            for (int b = 0; b < 32; b++)
                if (arr_write_en[b]) arr_dataout[8*b +: 8] = arr_datain[8*b +: 8];
    end

    // Line memory: unwritten lines return a per-word address pattern.
    logic [255:0] mem_model [logic [31:0]];
    int           n_rd = 0, n_wb = 0;
    logic [31:0]  last_rd_addr = '0, last_wb_addr = '0;

    function automatic logic [31:0] fill_word(input logic [31:0] a);
        return {a[31:2], 2'b00} ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [255:0] line_of(input logic [31:0] a);
        logic [255:0] l;
        if (mem_model.exists(a)) return mem_model[a];
        for (int w = 0; w < 8; w++) l[32*w +: 32] = fill_word({a[31:5], w[2:0], 2'b00});
        return l;
    endfunction

    initial begin
        int cnt;
        cnt        = 0;
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pmem_resp = 1'b0;
                cnt       = 0;
            end else if (pmem_resp) begin
                pmem_resp = 1'b0;
            end else if (pmem_read || pmem_write) begin
                check("pmem_exclusive", pmem_read & pmem_write, 0);
                cnt++;
                if (cnt == LAT) begin
                    cnt       = 0;
                    pmem_resp = 1'b1;
                    if (pmem_write) begin
                        mem_model[pmem_address] = pmem_wdata;
                        last_wb_addr = pmem_address;
                        n_wb++;
                    end else begin
                        pmem_rdata   = line_of(pmem_address);
                        last_rd_addr = pmem_address;
                        n_rd++;
                    end
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // CPU side: expected read data is queued at issue and popped at mem_resp.
    logic [31:0] sb_q [$];

    task automatic do_req(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] be, input logic [31:0] exp, input int exp_lat);
        int   lat;
        logic got;
        logic [31:0] e;
        @(negedge clk);
        mem_read        = !wr;
        mem_write       = wr;
        mem_address     = a;
        mem_wdata       = wd;
        mem_byte_enable = be;
        if (!wr) sb_q.push_back(exp);
        lat = 0;
        got = 1'b0;
        while (lat < 200 && !got) begin
            @(posedge clk);
            #1;
            lat++;
            if (mem_resp) got = 1'b1;
        end
        check("resp_seen", got, 1);
        if (!wr && sb_q.size() != 0) begin
            e = sb_q.pop_front();
            if (got) check("rdata", mem_rdata, e);
        end
        if (got && exp_lat != 0) check("latency", lat, exp_lat);
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(posedge clk);
        #1;
        check("resp_one_cycle", mem_resp, 0);
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        int          exp_lat;
        int          exp_rd;
        int          exp_wb;
        logic [31:0] exp_rd_addr;
        logic [31:0] exp_wb_addr;
        logic [31:0] exp_we;
    } vec_t;

    vec_t tbl [9];

    initial begin
        int rd0, wb0, cyc;
        logic [255:0] wb_line;

        tbl[0] = '{1'b0, 32'h40,  32'h0,         4'h0, fill_word(32'h40),  6,  1, 0, 32'h40,  32'h0,  32'h0};
        tbl[1] = '{1'b0, 32'h44,  32'h0,         4'h0, fill_word(32'h44),  2,  0, 0, 32'h0,   32'h0,  32'h0};
        tbl[2] = '{1'b1, 32'h48,  32'hDEADBEEF,  4'h5, 32'h0,              2,  0, 0, 32'h0,   32'h0,  32'h500};
        tbl[3] = '{1'b0, 32'h148, 32'h0,         4'h0, fill_word(32'h148), 10, 1, 1, 32'h140, 32'h40, 32'h0};
        tbl[4] = '{1'b0, 32'h48,  32'h0,         4'h0, 32'h5AAD00EF,       6,  1, 0, 32'h40,  32'h0,  32'h0};
        tbl[5] = '{1'b0, 32'h4C,  32'h0,         4'h0, fill_word(32'h4C),  2,  0, 0, 32'h0,   32'h0,  32'h0};
        tbl[6] = '{1'b1, 32'h60,  32'h12345678,  4'hF, 32'h0,              6,  1, 0, 32'h60,  32'h0,  32'hF};
        tbl[7] = '{1'b0, 32'h60,  32'h0,         4'h0, 32'h12345678,       2,  0, 0, 32'h0,   32'h0,  32'h0};
        tbl[8] = '{1'b0, 32'h7C,  32'h0,         4'h0, fill_word(32'h7C),  2,  0, 0, 32'h0,   32'h0,  32'h0};

        rst = 1'b1;
        mem_read = 1'b0; mem_write = 1'b0;
        mem_address = '0; mem_wdata = '0; mem_byte_enable = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_resp",     mem_resp,     0);
        check("rst_pmem_read",    pmem_read,    0);
        check("rst_pmem_write",   pmem_write,   0);
        check("rst_arr_write_en", arr_write_en, 0);
        check("rst_mem_rdata",    mem_rdata,    0);
        check("rst_pmem_address", pmem_address, 0);
        check("rst_pmem_wdata",   pmem_wdata,   0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            rd0 = n_rd;
            wb0 = n_wb;
            do_req(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].be, tbl[i].exp_rdata, tbl[i].exp_lat);
            check($sformatf("fills_%0d", i), n_rd - rd0, tbl[i].exp_rd);
            check($sformatf("writebacks_%0d", i), n_wb - wb0, tbl[i].exp_wb);
            if (tbl[i].exp_rd != 0) check($sformatf("fill_addr_%0d", i), last_rd_addr, tbl[i].exp_rd_addr);
            if (tbl[i].exp_wb != 0) check($sformatf("wb_addr_%0d", i), last_wb_addr, tbl[i].exp_wb_addr);
            if (tbl[i].exp_we != 0) check($sformatf("byte_mask_%0d", i), last_we, tbl[i].exp_we);
            if (i == 3) begin
                wb_line = mem_model.exists(32'h40) ? mem_model[32'h40] : '0;
                check("wb_merged_word", wb_line[64 +: 32], 32'h5AAD00EF);
                check("wb_word0",       wb_line[0 +: 32],  fill_word(32'h40));
`ifdef CACHE_PERF_EN
                check("perf_hits",       perf_hits,       2);
                check("perf_misses",     perf_misses,     2);
                check("perf_writebacks", perf_writebacks, 1);
`endif
            end
        end

        // Reset while a fill is outstanding drops the request and all state.
        @(negedge clk);
        mem_read    = 1'b1;
        mem_address = 32'h100;
        cyc = 0;
        while (cyc < 20 && !pmem_read) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("alloc_reached", pmem_read, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        mem_read = 1'b0;
        check("midrst_pmem_read",  pmem_read,  0);
        check("midrst_pmem_write", pmem_write, 0);
        check("midrst_mem_resp",   mem_resp,   0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        rd0 = n_rd;
        do_req(1'b0, 32'h40, 32'h0, 4'h0, fill_word(32'h40), 6);
        check("post_rst_miss", n_rd - rd0, 1);
        check("post_rst_fill_addr", last_rd_addr, 32'h40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
